// File: rtl/game_pkg.sv
// Shared types and helpers for the guess/key load register arbiter.
package game_pkg;

   localparam int unsigned DATA_W_DEF = 4;
   localparam int unsigned MAX_REQ    = 8;
   localparam int unsigned IDX_W      = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GRANT    = 2'd1,
      ST_COOLDOWN = 2'd2
   } state_e;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of elig scanning rr, rr+1, ... modulo n.
   function automatic rr_pick_t rr_first_set(input logic [MAX_REQ-1:0] elig,
                                             input int unsigned        n,
                                             input int unsigned        rr);
      rr_pick_t    r;
      int unsigned j;
      r.valid = 1'b0;
      r.idx   = '0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         j = (rr + k) % n;
         if (k < n && !r.valid && elig[3'(j)]) begin
            r.valid = 1'b1;
            r.idx   = IDX_W'(j);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin winner selection over the eligible vector.
module rr_priority_picker
   import game_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] eligible_i,
   input  logic [IDW-1:0]     rr_i,
   output logic               valid_o,
   output logic [IDW-1:0]     win_o
);

   rr_pick_t pick;

   always_comb begin
      pick    = rr_first_set(MAX_REQ'(eligible_i), NUM_REQ, 32'(rr_i));
      valid_o = pick.valid;
      win_o   = IDW'(pick.idx);
   end

endmodule

// File: rtl/load_register_arbiter.sv
// Round-robin arbiter sharing one parallel-load register between players,
// with per-player load budgets and a cooldown gap after each load.
module load_register_arbiter
   import game_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned MAX_LOADS = 15,
   parameter int unsigned COOLDOWN  = 1,
   localparam int unsigned IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int unsigned CW       = $clog2(MAX_LOADS + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic                      clear_budget,
   output logic                      load,
   output logic [DATA_W-1:0]         load_data,
   output logic [NUM_REQ-1:0]        ack,
   output logic [IDW-1:0]            grant_id,
   output logic                      busy,
   output logic [NUM_REQ-1:0]        exhausted
);

   state_e              state_q, state_d;
   logic [3:0]          cd_q, cd_d;
   logic                load_q, load_d;
   logic [DATA_W-1:0]   load_data_q, load_data_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic [IDW-1:0]      grant_id_q, grant_id_d;
   logic [IDW-1:0]      rr_q, rr_d;
   logic                busy_q, busy_d;
   logic [CW-1:0]       count_q [NUM_REQ];
   logic [CW-1:0]       count_d [NUM_REQ];
   logic [NUM_REQ-1:0]  exhausted_q, exhausted_d;
   logic [NUM_REQ-1:0]  eligible;
   logic                pick_valid;
   logic [IDW-1:0]      pick_idx;
   logic [DATA_W-1:0]   pick_data;
   logic                inc;

   assign eligible = req & ~exhausted_q;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_picker (
      .eligible_i (eligible),
      .rr_i       (rr_q),
      .valid_o    (pick_valid),
      .win_o      (pick_idx)
   );

   // Winner's data lane.
   always_comb begin
      pick_data = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (pick_idx == IDW'(i)) pick_data = req_data[i*DATA_W +: DATA_W];
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      cd_d        = cd_q;
      load_d      = 1'b0;
      ack_d       = '0;
      load_data_d = load_data_q;
      grant_id_d  = grant_id_q;
      rr_d        = rr_q;
      inc         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               load_data_d = pick_data;
               grant_id_d  = pick_idx;
               load_d      = 1'b1;
               ack_d       = NUM_REQ'(1) << pick_idx;
               state_d     = ST_GRANT;
            end
         end
         ST_GRANT: begin
            inc  = 1'b1;
            rr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
            if (COOLDOWN > 0) begin
               state_d = ST_COOLDOWN;
               cd_d    = 4'(COOLDOWN);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_COOLDOWN: begin
            if (cd_q <= 4'd1) begin
               state_d = ST_IDLE;
               cd_d    = '0;
            end else begin
               cd_d = cd_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Saturating per-player load counters; a clear outranks a same-cycle increment.
   always_comb begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         count_d[i] = count_q[i];
         if (clear_budget) begin
            count_d[i] = '0;
         end else if (inc && grant_id_q == IDW'(i) && count_q[i] != CW'(MAX_LOADS)) begin
            count_d[i] = count_q[i] + CW'(1);
         end
         exhausted_d[i] = (count_d[i] == CW'(MAX_LOADS));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cd_q        <= '0;
         load_q      <= 1'b0;
         load_data_q <= '0;
         ack_q       <= '0;
         grant_id_q  <= '0;
         rr_q        <= '0;
         busy_q      <= 1'b0;
         exhausted_q <= '0;
         for (int i = 0; i < int'(NUM_REQ); i++) count_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         cd_q        <= cd_d;
         load_q      <= load_d;
         load_data_q <= load_data_d;
         ack_q       <= ack_d;
         grant_id_q  <= grant_id_d;
         rr_q        <= rr_d;
         busy_q      <= busy_d;
         exhausted_q <= exhausted_d;
         for (int i = 0; i < int'(NUM_REQ); i++) count_q[i] <= count_d[i];
      end
   end

   assign load      = load_q;
   assign load_data = load_data_q;
   assign ack       = ack_q;
   assign grant_id  = grant_id_q;
   assign busy      = busy_q;
   assign exhausted = exhausted_q;

endmodule

// File: tb/tb_load_register_arbiter.sv
// Directed bench: instance a (MAX_LOADS=3, COOLDOWN=1), instance b (COOLDOWN=0).
module tb_load_register_arbiter;

   logic       clk;
   logic       reset;
   logic [1:0] a_req, b_req;
   logic [7:0] a_data, b_data;
   logic       a_clr, b_clr;
   logic       a_load, b_load;
   logic [3:0] a_ldata, b_ldata;
   logic [1:0] a_ack, b_ack;
   logic       a_gid, b_gid;
   logic       a_busy, b_busy;
   logic [1:0] a_exh, b_exh;

   int checks   = 0;
   int failures = 0;

   load_register_arbiter #(.NUM_REQ(2), .DATA_W(4), .MAX_LOADS(3), .COOLDOWN(1)) dut_a (
      .clk(clk), .reset(reset), .req(a_req), .req_data(a_data), .clear_budget(a_clr),
      .load(a_load), .load_data(a_ldata), .ack(a_ack), .grant_id(a_gid),
      .busy(a_busy), .exhausted(a_exh)
   );

   load_register_arbiter #(.NUM_REQ(2), .DATA_W(4), .MAX_LOADS(15), .COOLDOWN(0)) dut_b (
      .clk(clk), .reset(reset), .req(b_req), .req_data(b_data), .clear_budget(b_clr),
      .load(b_load), .load_data(b_ldata), .ack(b_ack), .grant_id(b_gid),
      .busy(b_busy), .exhausted(b_exh)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check the strobe/ack/data triple of instance a.
   task automatic chk_a(input string tag, input logic ld, input logic [1:0] ak, input logic [3:0] dt);
      chk({tag, ".load"}, 32'(a_load), 32'(ld));
      chk({tag, ".ack"},  32'(a_ack),  32'(ak));
      chk({tag, ".data"}, 32'(a_ldata), 32'(dt));
   endtask

   initial begin
      reset = 1'b1;
      a_req = '0; b_req = '0; a_data = '0; b_data = '0; a_clr = 1'b0; b_clr = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk_a("rst", 1'b0, 2'b00, 4'h0);
      chk("rst.gid",  32'(a_gid),  32'd0);
      chk("rst.busy", 32'(a_busy), 32'd0);
      chk("rst.exh",  32'(a_exh),  32'd0);
      chk("rst.b_load", 32'(b_load), 32'd0);

      // Single request from player 0.
      a_req = 2'b01; a_data = 8'hCA;
      tick();
      chk_a("t1", 1'b1, 2'b01, 4'hA);
      chk("t1.gid",  32'(a_gid),  32'd0);
      chk("t1.busy", 32'(a_busy), 32'd1);
      a_req = 2'b00;
      tick();
      chk_a("t2_cool", 1'b0, 2'b00, 4'hA);
      chk("t2.busy", 32'(a_busy), 32'd1);
      tick();
      chk("t3.busy", 32'(a_busy), 32'd0);
      chk("t3.load", 32'(a_load), 32'd0);

      // Both request; rr now favours player 1, loads 3 cycles apart.
      a_req = 2'b11; a_data = 8'hC3;
      tick(); chk_a("t4", 1'b1, 2'b10, 4'hC);
      chk("t4.gid", 32'(a_gid), 32'd1);
      tick(); chk_a("t5", 1'b0, 2'b00, 4'hC);
      tick(); chk_a("t6", 1'b0, 2'b00, 4'hC);
      tick(); chk_a("t7", 1'b1, 2'b01, 4'h3);
      tick(); chk_a("t8", 1'b0, 2'b00, 4'h3);
      tick(); chk_a("t9", 1'b0, 2'b00, 4'h3);
      tick(); chk_a("t10", 1'b1, 2'b10, 4'hC);
      a_req = 2'b00;
      tick(); tick();

      // Third load of player 0 exhausts it.
      a_req = 2'b01; a_data = 8'hC5;
      tick(); chk_a("t13", 1'b1, 2'b01, 4'h5);
      tick(); chk("t14.exh", 32'(a_exh), 32'h1);
      tick();
      tick(); chk_a("t16_locked", 1'b0, 2'b00, 4'h5);
      chk("t16.busy", 32'(a_busy), 32'd0);
      tick(); chk("t17.load", 32'(a_load), 32'd0);

      // Player 1 still served; clear coincides with its GRANT cycle.
      a_req = 2'b11; a_data = 8'h95;
      tick(); chk_a("t18", 1'b1, 2'b10, 4'h9);
      a_clr = 1'b1;
      tick(); chk("t19.exh_clr", 32'(a_exh), 32'h0);
      chk("t19.busy", 32'(a_busy), 32'd1);
      a_clr = 1'b0;
      tick();
      tick(); chk_a("t21_regrant", 1'b1, 2'b01, 4'h5);
      tick(); tick();
      tick(); chk_a("t24", 1'b1, 2'b10, 4'h9);

      // Reset during GRANT: no further load, state cleared, player 0 wins first.
      reset = 1'b1;
      tick();
      chk_a("t25_rst", 1'b0, 2'b00, 4'h0);
      chk("t25.gid",  32'(a_gid),  32'd0);
      chk("t25.busy", 32'(a_busy), 32'd0);
      chk("t25.exh",  32'(a_exh),  32'd0);
      reset = 1'b0;
      tick(); chk_a("t26", 1'b1, 2'b01, 4'h5);
      a_req = 2'b00;

      // Instance b: no cooldown, loads every 2 cycles, data sampled at arbitration.
      b_req = 2'b10; b_data = 8'h72;
      tick();
      chk("b1.load", 32'(b_load), 32'd1);
      chk("b1.data", 32'(b_ldata), 32'h7);
      chk("b1.ack",  32'(b_ack),  32'h2);
      b_data = 8'hE2;
      tick();
      chk("b2.load", 32'(b_load), 32'd0);
      chk("b2.data_held", 32'(b_ldata), 32'h7);
      chk("b2.busy", 32'(b_busy), 32'd0);
      tick();
      chk("b3.load", 32'(b_load), 32'd1);
      chk("b3.data", 32'(b_ldata), 32'hE);
      tick();
      chk("b4.load", 32'(b_load), 32'd0);
      tick();
      chk("b5.load", 32'(b_load), 32'd1);
      b_req = 2'b00;
      tick(); tick();
      chk("b7.load", 32'(b_load), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_register_arbiter.md
Name: load_register_arbiter

Overview:
Shares one 4-bit parallel-load register (the game's guess/key holding register) between several player requesters.
- Arbitrates load requests round-robin.
- Drives the register's load strobe and input data.
- Acknowledges the winning player.
- Enforces a per-player load budget (attempt limit) and a cooldown gap between consecutive loads.
- Sits between the player input logic and the shared load register; its outputs drive the register's load and data inputs directly.

Parameters:
NUM_REQ, 2, number of requesters (players), range 2..8
DATA_W, 4, width of load data, matches the shared register
MAX_LOADS, 15, loads allowed per requester before lock-out, range 1..255
COOLDOWN, 1, idle cycles forced after each load, range 0..15

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
req  input  NUM_REQ  per-requester load request, level
req_data  input  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
clear_budget  input  1  one-cycle pulse; zeroes all load counters
load  output  1  load strobe to the shared register, one cycle per grant
load_data  output  DATA_W  data to the shared register, valid when load=1
ack  output  NUM_REQ  one-hot, one-cycle pulse to the granted requester, coincident with load
grant_id  output  clog2(NUM_REQ)  index of the current or last granted requester
busy  output  1  high in GRANT and COOLDOWN states
exhausted  output  NUM_REQ  bit i high while count[i] == MAX_LOADS

Behaviour:
- All outputs are registered. Reset is synchronous and active-high, and dominates every other input.
- On reset:
  - state=IDLE; load=0, ack=0, load_data=0, grant_id=0, busy=0.
  - All counters 0, so exhausted=0.
  - Round-robin pointer rr=0, meaning requester 0 has top priority.
- Eligibility: eligible = req & ~exhausted. Requests from exhausted requesters are ignored: no ack and no load.
- FSM states: IDLE, GRANT, COOLDOWN.
  - IDLE: if eligible is nonzero, select the first set bit scanning rr, rr+1, ... mod NUM_REQ. In the same edge:
    - capture that requester's req_data into load_data;
    - set grant_id to the winner;
    - go to GRANT.
  - IDLE: otherwise stay in IDLE with load=0.
  - GRANT (exactly 1 cycle):
    - load=1, ack[grant_id]=1;
    - count[grant_id] increments;
    - rr becomes (grant_id+1) mod NUM_REQ;
    - next state is COOLDOWN if COOLDOWN>0, else IDLE.
  - COOLDOWN: stay for exactly COOLDOWN cycles (4-bit down-counter), ignore req, then go to IDLE.
- Latency: req sampled high in IDLE at edge N gives load/ack high during cycle N+1. Minimum spacing between loads is 2+COOLDOWN cycles.
- Handshake:
  - One ack means one load.
  - A requester that keeps req high after ack is treated as making a new request at the next IDLE arbitration.
  - Data is sampled only at the arbitration edge. Changes to req_data afterwards do not affect load_data.
  - A req dropped before arbitration is never granted. There is no latching of missed requests.
- Counters are clog2(MAX_LOADS+1) bits wide and saturate at MAX_LOADS. Once a counter reaches MAX_LOADS, exhausted[i] goes high in the same cycle the counter updates.
- clear_budget:
  - all counters read 0 after the edge;
  - if it coincides with a GRANT increment, clear wins and the count is 0, not 1;
  - it does not affect state, rr, or an in-progress GRANT/COOLDOWN.
- Simultaneous requests: strict round-robin, with no requester granted twice while another eligible requester waits.
- Reset asserted during GRANT or COOLDOWN: the next cycle is IDLE with load=0 and ack=0. No partial load is issued.
- load_data holds its last value when load=0.
- grant_id holds until the next arbitration.

Decomposition:
- Shared package `game_pkg`:
  - FSM state enum (IDLE, GRANT, COOLDOWN);
  - DATA_W default constant;
  - helper function for round-robin first-set-bit search.
- One sub-module is natural: `rr_priority_picker`. It is combinational; inputs are an eligible vector and the rr pointer; outputs are a valid flag and the winner index.
- The counters and FSM stay in the top module.

Test Plan:
- Reset, then req=2'b01, req_data[3:0]=4'hA → one cycle later load=1, load_data=4'hA, ack=2'b01, count[0]=1; load=0 during COOLDOWN cycle; busy=1 for 2 cycles.
- req=2'b11 held with data 4'h3/4'hC → loads alternate 4'h3, 4'hC, 4'h3, ... with ack 01, 10, 01, ...; each load spaced 3 cycles apart (COOLDOWN=1).
- MAX_LOADS=3, req[0] held alone → exactly 3 acks; exhausted[0]=1 after the third; further req[0] gives no load; req[1] is still served.
- clear_budget asserted in the same cycle as a GRANT for requester 1 → count[1]=0 afterwards; exhausted cleared; a previously exhausted requester is granted again.
- reset asserted during a GRANT cycle → next cycle load=0, ack=0, state IDLE, counters 0, rr=0; with req=2'b11 pending, requester 0 wins first.
- COOLDOWN=0, req[1] held → load pulses every 2 cycles; req_data changed the cycle after arbitration → load_data shows the sampled value, not the new one.
